// File: rtl/mult_div_seq.sv
// Iterative multiply/divide sequencer feeding the HI/LO registers.
// Multiply is shift-add on operand magnitudes into a 2*WIDTH accumulator.
// Divide is restoring division, one quotient bit per clock.
// Each operation takes WIDTH RUN cycles, then one FIX cycle that applies
// the signs and loads HI/LO. A divide by zero finishes immediately and
// raises a one-cycle flag, leaving HI/LO untouched.
`timescale 1ns/1ps

module mult_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic                 neg_q, neg_d;     // product / quotient is negative
    logic                 rneg_q, rneg_d;   // remainder is negative
    logic [WIDTH-1:0]     mcand_q, mcand_d; // |a| for multiply, |b| for divide
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // product, or dividend/quotient in low half
    logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operand magnitudes and per-iteration datapath values.
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ok;
    logic [WIDTH-1:0]     rem_next;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Operand magnitudes: two's-complement negate only in signed mode.
    always_comb begin
        a_mag = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // One shift-add multiply step: add the multiplicand into the upper
    // half when the current multiplier bit is set, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // One restoring-division step: shift the next dividend bit into a
    // WIDTH+1-bit trial remainder and subtract the divisor if it fits.
    // The restored remainder is always below the divisor, so WIDTH bits
    // are enough to keep it between steps.
    always_comb begin
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, mcand_q});
        div_diff  = div_shift[WIDTH-1:0] - mcand_q;
        rem_next  = div_ok ? div_diff : div_shift[WIDTH-1:0];
        div_next  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
    end

    // Sign correction applied in FIX.
    always_comb begin
        prod_fix = neg_q  ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Next-state and register-update logic for the sequencer.
    // NOTE: every _d gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op && (b == '0)) begin
                        // Divide by zero: report and stay idle, HI/LO untouched.
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        op_d    = op;
                        neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d  = sgn & a[WIDTH-1];
                        mcand_d = op ? b_mag : a_mag;
                        acc_d   = {{WIDTH{1'b0}}, (op ? a_mag : b_mag)};
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (op_q) begin
                    acc_d = div_next;
                    rem_d = rem_next;
                end else begin
                    acc_d = mul_next;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq at WIDTH=32.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_mult_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;
    int n;
    int done_seen;

    always #5 clk = ~clk;

    mult_div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .sgn      (sgn),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle start; returns on the falling edge after the
    // accepting rising edge, with the operand inputs scrambled.
    task automatic issue(input logic o, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1; op = o; sgn = s; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;
    endtask

    // Count falling edges until done is seen, bounded at 100.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < 100);
    endtask

    // Full operation with latency, result and pulse-width checks.
    task automatic run_op(input string tag, input logic o, input logic s,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cnt;
        issue(o, s, av, bv);
        check({tag, "_busy_start"}, busy, 1);
        wait_done(cnt);
        check({tag, "_latency"}, cnt, 33);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_divzero"}, div_zero, 0);
        check({tag, "_busy_done"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;

        // Signed multiply: -3 * 7 = -21.
        run_op("mul_s", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // Unsigned multiply: (2^32-1)^2.
        run_op("mul_u", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        // Reset for two cycles in the middle of a multiply.
        issue(1'b0, 1'b0, 32'h10, 32'h20);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst_done_seen", done_seen, 0);
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        reset = 1'b1;
        run_op("post_rst", 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h200);

        // Divides: signed truncates toward zero, remainder follows dividend.
        run_op("div_s", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_u", 1'b1, 1'b0, 32'd7, 32'd2, 32'd1, 32'd3);

        // Preload hi/lo = 0x1234/0x5678, then divide by zero.
        run_op("preload", 1'b1, 1'b0, 32'h5678_1234, 32'h0001_0000, 32'h1234, 32'h5678);
        issue(1'b1, 1'b1, 32'd5, 32'd0);
        check("dz_done", done, 1);
        check("dz_flag", div_zero, 1);
        check("dz_busy", busy, 0);
        check("dz_hi", hi, 32'h1234);
        check("dz_lo", lo, 32'h5678);
        @(negedge clk);
        check("dz_done_pulse", done, 0);
        check("dz_flag_pulse", div_zero, 0);
        check("dz_busy_after", busy, 0);

        // Signed overflow: most-negative / -1 wraps.
        run_op("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Start pulsed during RUN with other operands is ignored.
        issue(1'b0, 1'b0, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("ign_latency", n, 27);
        check("ign_hi", hi, 0);
        check("ign_lo", lo, 32'd30);

        // Start held high through done: second op accepted in the done cycle.
        @(negedge clk);
        start = 1'b1; op = 1'b0; sgn = 1'b0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        a = 32'd9; b = 32'd11;
        check("hold_busy1", busy, 1);
        wait_done(n);
        check("hold_latency1", n, 33);
        check("hold_lo1", lo, 32'd12);
        check("hold_hi1", hi, 0);
        @(negedge clk);
        start = 1'b0;
        check("hold_busy2", busy, 1);
        check("hold_done_gap", done, 0);
        wait_done(n);
        check("hold_latency2", n, 33);
        check("hold_lo2", lo, 32'd99);
        check("hold_hi2", hi, 0);
        @(negedge clk);
        check("hold_done_pulse", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
